// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write arbiter: FSM state encoding and the
// round-robin winner search used by rr_pick.
package fifo_arb_pkg;

  // Arbiter FSM states (IDLE = 1'b0, BURST = 1'b1).
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_t;

  // Widest requester vector the search function handles.
  localparam int unsigned RR_MAX = 8;

  // Round-robin search starting at (last+1) mod nreq.
  // Returns {any, winner[2:0]}; winner is 0 when nothing is requesting.
  function automatic logic [3:0] rr_search(
    input logic [RR_MAX-1:0] req,
    input int unsigned       nreq,
    input logic [2:0]        last
  );
    logic        found;
    logic [2:0]  win;
    int unsigned idx;
    found = 1'b0;
    win   = '0;
    for (int unsigned i = 1; i <= RR_MAX; i++) begin
      if (i <= nreq) begin
        // last < nreq and i <= nreq, so one subtraction performs the modulo
        idx = 32'(last) + i;
        if (idx >= nreq) idx = idx - nreq;
        if (!found && req[idx[2:0]]) begin
          found = 1'b1;
          win   = idx[2:0];
        end
      end
    end
    return {found, win};
  endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin winner search over the requester vector.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_last,
  output logic [IW-1:0]   o_winner,
  output logic            o_any
);

  logic [RR_MAX-1:0] w_req;
  logic [2:0]        w_last;
  logic [3:0]        w_res;

  // Widen inputs to the search function's fixed width and split the result.
  always_comb begin
    w_req    = RR_MAX'(i_req);
    w_last   = 3'(i_last);
    w_res    = rr_search(w_req, NREQ, w_last);
    o_any    = w_res[3];
    o_winner = IW'(w_res[2:0]);
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Multi-requester write arbiter in front of a FIFO write port.
// Round-robin grants, up to BURST words per grant, stalls on fifo_full,
// new grants blocked by fifo_near_full.
// Macro FIFO_WR_ARB_LOCK_EN: defined -> bursts of up to BURST words;
// undefined -> one word per grant (BURST treated as 1).
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned DSIZE = 8,
  parameter int unsigned BURST = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DSIZE-1:0]    req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     fifo_full,
  input  logic                     fifo_near_full,
  output logic                     fifo_wen,
  output logic [DSIZE-1:0]         fifo_wdata,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(BURST) + 1;
`ifdef FIFO_WR_ARB_LOCK_EN
  localparam int unsigned BLEN = BURST;
`else
  localparam int unsigned BLEN = 1;
`endif

  arb_state_t  r_state;
  logic [IW-1:0] r_grant;
  logic [IW-1:0] r_last;
  logic [CW-1:0] r_wcnt;

  logic          w_any;
  logic [IW-1:0] w_winner;
  logic          w_cur_valid;
  logic          w_ready;
  logic          w_xfer;
  logic          w_last_word;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req    (req_valid),
    .i_last   (r_last),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  // Handshake for the current grantee; clr and rst suppress the transfer
  // so the requester never sees an accept that the FIFO did not take.
  always_comb begin
    w_cur_valid        = req_valid[r_grant];
    w_ready            = (r_state == ST_BURST) && !fifo_full && !clr && !rst;
    w_xfer             = w_ready && w_cur_valid;
    w_last_word        = (r_wcnt == CW'(BLEN - 1));
    req_ready          = '0;
    req_ready[r_grant] = w_ready;
  end

  assign fifo_wen   = w_xfer;
  assign fifo_wdata = req_data[32'(r_grant)*DSIZE +: DSIZE];
  assign grant_id   = r_grant;
  assign busy       = (r_state == ST_BURST);

  // Arbitration FSM: grant on IDLE, count words and release on BURST.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_last  <= IW'(NREQ - 1);
      r_wcnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!clr && w_any && !fifo_full && !fifo_near_full) begin
            r_state <= ST_BURST;
            r_grant <= w_winner;
            r_wcnt  <= '0;
          end
        end
        ST_BURST: begin
          if (clr || !w_cur_valid || (w_xfer && w_last_word)) begin
            r_state <= ST_IDLE;
            r_last  <= r_grant;
          end
          if (w_xfer) r_wcnt <= r_wcnt + CW'(1);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed testbench for fifo_wr_arb (NREQ=4, DSIZE=8, BURST=4).
// Expected burst length follows FIFO_WR_ARB_LOCK_EN.
module tb_fifo_wr_arb;

`ifdef FIFO_WR_ARB_LOCK_EN
  localparam int EB = 4;
`else
  localparam int EB = 1;
`endif

  logic        clk = 1'b0;
  logic        rst, clr;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_full, fifo_near_full;
  logic        fifo_wen;
  logic [7:0]  fifo_wdata;
  logic [1:0]  grant_id;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  fifo_wr_arb #(.NREQ(4), .DSIZE(8), .BURST(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .clr            (clr),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .fifo_full      (fifo_full),
    .fifo_near_full (fifo_near_full),
    .fifo_wen       (fifo_wen),
    .fifo_wdata     (fifo_wdata),
    .grant_id       (grant_id),
    .busy           (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    clr            = 1'b0;
    req_valid      = '0;
    req_data       = 32'hA3A2A1A0;
    fifo_full      = 1'b0;
    fifo_near_full = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b1; req_valid = 4'hF; req_data = 32'hA3A2A1A0;
    fifo_full = 1'b0; fifo_near_full = 1'b0;
    #1;
    n_total++;
    if (fifo_wen !== 1'b0 || req_ready !== 4'b0000) $display("FAIL reset_comb: wen=%b ready=%b want 0/0000", fifo_wen, req_ready);
    else n_pass++;
    tick();
    rst = 1'b0; clr = 1'b0; req_valid = '0;
    #1;
    n_total++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++;
    if (grant_id !== 2'd0) $display("FAIL reset_grant: got %0d want 0", grant_id); else n_pass++;
    n_total++;
    if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", req_ready); else n_pass++;
    n_total++;
    if (fifo_wen !== 1'b0) $display("FAIL reset_wen: got %b want 0", fifo_wen); else n_pass++;
  endtask

  // Requesters 0 and 2 always valid: grants alternate with one idle cycle.
  task automatic test_alternate();
    logic [15:0] e, o;
    do_reset();
    req_valid = 4'b0101;
    for (int b = 0; b < 4; b++) begin
      logic [1:0] g;
      g = (b % 2 == 0) ? 2'd0 : 2'd2;
      #1;
      n_total++;
      if ({busy, fifo_wen, req_ready} !== 6'b0) $display("FAIL alt_idle b%0d: got %b want 000000", b, {busy, fifo_wen, req_ready});
      else n_pass++;
      tick();
      for (int w = 0; w < EB; w++) begin
        #1;
        e = {1'b1, 1'b1, g, 4'b0001 << g, 8'hA0 | {6'b0, g}};
        o = {busy, fifo_wen, grant_id, req_ready, fifo_wdata};
        n_total++;
        if (o !== e) $display("FAIL alt_burst b%0d w%0d: got %h want %h", b, w, o, e);
        else n_pass++;
        tick();
      end
    end
    req_valid = '0;
  endtask

  // Requester 1 stalled by fifo_full for 3 cycles after its 2nd word.
  task automatic test_stall();
    logic        st, exp_wen;
    int unsigned cnt, sent, stalls, ngot;
    logic [7:0]  got [4];
    logic [13:0] e, o;
    do_reset();
    st = 1'b0; cnt = 0; sent = 0; stalls = 0; ngot = 0;
    for (int i = 0; i < 4; i++) got[i] = '0;
    req_valid = 4'b0010;
    for (int c = 0; c < 20 && sent < 4; c++) begin
      fifo_full = (sent >= 2 && stalls < 3);
      if (fifo_full) stalls++;
      req_data = {4{8'h11 + 8'(sent)}};
      exp_wen  = st && !fifo_full;
      #1;
      e = {st, exp_wen, exp_wen ? 4'b0010 : 4'b0000, 8'h11 + 8'(sent)};
      o = {busy, fifo_wen, req_ready, fifo_wdata};
      n_total++;
      if (o !== e) $display("FAIL stall c%0d: got %h want %h", c, o, e);
      else n_pass++;
      if (fifo_wen && ngot < 4) begin
        got[ngot] = fifo_wdata;
        ngot++;
      end
      if (st) begin
        if (!fifo_full) begin
          sent++; cnt++;
          if (cnt == EB) st = 1'b0;
        end
      end else if (!fifo_full) begin
        st = 1'b1; cnt = 0;
      end
      tick();
    end
    fifo_full = 1'b0;
    req_valid = '0;
    n_total++;
    if (ngot !== 4) $display("FAIL stall_count: got %0d writes want 4", ngot); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (got[i] !== 8'h11 + 8'(i)) $display("FAIL stall_order w%0d: got %h want %h", i, got[i], 8'h11 + 8'(i));
      else n_pass++;
    end
  endtask

  // near_full blocks new grants only; grant follows one cycle after release.
  task automatic test_near_full();
    do_reset();
    req_valid = 4'hF;
    fifo_near_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_total++;
      if ({busy, fifo_wen} !== 2'b00) $display("FAIL nf_block c%0d: got %b want 00", c, {busy, fifo_wen});
      else n_pass++;
      tick();
    end
    fifo_near_full = 1'b0;
    #1;
    n_total++;
    if (busy !== 1'b0) $display("FAIL nf_release_idle: got %b want 0", busy); else n_pass++;
    tick();
    #1;
    n_total++;
    if ({busy, grant_id, fifo_wen} !== 4'b1001) $display("FAIL nf_grant: got %b want 1001", {busy, grant_id, fifo_wen});
    else n_pass++;
    req_valid = '0;
  endtask

  // Requester 3 drops valid after one word; next grant must be requester 0.
  task automatic test_drop();
    do_reset();
    req_valid = 4'b1001;
    #1;
    n_total++;
    if (busy !== 1'b0) $display("FAIL drop_idle0: got %b want 0", busy); else n_pass++;
    tick();
    for (int w = 0; w < EB; w++) begin
      #1;
      n_total++;
      if ({busy, grant_id, fifo_wen} !== 4'b1001) $display("FAIL drop_g0 w%0d: got %b want 1001", w, {busy, grant_id, fifo_wen});
      else n_pass++;
      tick();
    end
    #1;
    n_total++;
    if (busy !== 1'b0) $display("FAIL drop_idle1: got %b want 0", busy); else n_pass++;
    tick();
    #1;
    n_total++;
    if ({busy, grant_id, fifo_wen} !== 4'b1111) $display("FAIL drop_g3: got %b want 1111", {busy, grant_id, fifo_wen});
    else n_pass++;
    tick();
`ifdef FIFO_WR_ARB_LOCK_EN
    req_valid = 4'b0011;
    #1;
    n_total++;
    if ({busy, grant_id, fifo_wen} !== 4'b1110) $display("FAIL drop_gap: got %b want 1110", {busy, grant_id, fifo_wen});
    else n_pass++;
    tick();
`endif
    req_valid = 4'b0011;
    #1;
    n_total++;
    if (busy !== 1'b0) $display("FAIL drop_idle2: got %b want 0", busy); else n_pass++;
    tick();
    #1;
    n_total++;
    if ({busy, grant_id} !== 3'b100) $display("FAIL drop_next: got %b want 100", {busy, grant_id});
    else n_pass++;
    req_valid = '0;
  endtask

  // clr and rst each land on a transfer cycle.
  task automatic test_clr_rst();
    do_reset();
    req_valid = 4'b0110;
    #1;
    n_total++;
    if (busy !== 1'b0) $display("FAIL cr_idle0: got %b want 0", busy); else n_pass++;
    tick();
    #1;
    n_total++;
    if ({busy, grant_id, fifo_wen} !== 4'b1011) $display("FAIL cr_g1: got %b want 1011", {busy, grant_id, fifo_wen});
    else n_pass++;
    clr = 1'b1;
    #1;
    n_total++;
    if ({fifo_wen, req_ready} !== 5'b0) $display("FAIL cr_clr_wen: got %b want 00000", {fifo_wen, req_ready});
    else n_pass++;
    tick();
    clr = 1'b0;
    #1;
    n_total++;
    if (busy !== 1'b0) $display("FAIL cr_clr_idle: got %b want 0", busy); else n_pass++;
    tick();
    #1;
    n_total++;
    if ({busy, grant_id, fifo_wen} !== 4'b1101) $display("FAIL cr_g2: got %b want 1101", {busy, grant_id, fifo_wen});
    else n_pass++;
    rst = 1'b1;
    #1;
    n_total++;
    if (fifo_wen !== 1'b0) $display("FAIL cr_rst_wen: got %b want 0", fifo_wen); else n_pass++;
    tick();
    rst = 1'b0;
    #1;
    n_total++;
    if ({busy, grant_id} !== 3'b000) $display("FAIL cr_rst_idle: got %b want 000", {busy, grant_id});
    else n_pass++;
    tick();
    #1;
    n_total++;
    if ({busy, grant_id} !== 3'b101) $display("FAIL cr_after_rst: got %b want 101", {busy, grant_id});
    else n_pass++;
    req_valid = '0;
  endtask

  // All four valid: grant order 0,1,2,3,0.
  task automatic test_per_word();
    logic [15:0] e, o;
    do_reset();
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      logic [1:0] g;
      g = 2'(k % 4);
      #1;
      n_total++;
      if ({busy, fifo_wen} !== 2'b00) $display("FAIL pw_idle k%0d: got %b want 00", k, {busy, fifo_wen});
      else n_pass++;
      tick();
      for (int w = 0; w < EB; w++) begin
        #1;
        e = {1'b1, 1'b1, g, 4'b0001 << g, 8'hA0 | {6'b0, g}};
        o = {busy, fifo_wen, grant_id, req_ready, fifo_wdata};
        n_total++;
        if (o !== e) $display("FAIL pw_grant k%0d w%0d: got %h want %h", k, w, o, e);
        else n_pass++;
        tick();
      end
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_stall();
    test_near_full();
    test_drop();
    test_clr_rst();
    test_per_word();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
- REQ-001: Parameter NREQ, default 4, number of write requesters (2..8).
- REQ-002: Parameter DSIZE, default 8, word width; matches the FIFO DSIZE.
- REQ-003: Parameter BURST, default 4, maximum words per grant (1..16).
- REQ-004: Ports:
  - clk  in  1  write-domain clock; one clock only.
  - rst  in  1  reset, synchronous, active-high.
  - clr  in  1  synchronous abort to IDLE.
  - req_valid  in  NREQ  per-requester word valid.
  - req_data  in  NREQ*DSIZE  requester i data at bits [i*DSIZE +: DSIZE].
  - req_ready  out  NREQ  per-requester accept.
  - fifo_full  in  1  FIFO full flag.
  - fifo_near_full  in  1  FIFO near_full flag.
  - fifo_wen  out  1  FIFO write enable.
  - fifo_wdata  out  DSIZE  FIFO write data.
  - grant_id  out  $clog2(NREQ)  current grantee.
  - busy  out  1  high when state is not IDLE.

Function
- REQ-005: The FSM shall have two states, IDLE and BURST, held in registers.
- REQ-006: In IDLE, the FSM shall move to BURST on the next edge when any req_valid bit is high and fifo_full and fifo_near_full are both low. The winner shall be the first valid requester found by searching round-robin from (last_grant+1) mod NREQ.
- REQ-007: On the IDLE-to-BURST edge, grant_id shall load the winner and the word counter wcnt shall clear to 0. Latency from req_valid to the first possible write is one cycle.
- REQ-008: In BURST:
  - req_ready[grant_id] = !fifo_full.
  - All other req_ready bits = 0.
  - A transfer occurs when req_valid[grant_id] and req_ready[grant_id] are both high.
- REQ-009: fifo_wen shall equal the transfer condition combinationally. fifo_wdata shall equal req_data of grant_id in every cycle, whether or not a transfer occurs.
- REQ-010: Each transfer shall increment wcnt. wcnt is $clog2(BURST)+1 bits wide and does not wrap within a burst.
- REQ-011: BURST shall return to IDLE on the edge after any of these:
  - a transfer with wcnt == BURST-1;
  - a cycle with req_valid[grant_id] low;
  - clr high.
- REQ-012: On every BURST-to-IDLE edge, last_grant shall load grant_id.
- REQ-013: With fifo_full high in BURST, the FSM shall stay in BURST with no transfer (stall). A stall does not end the burst.
- REQ-014: fifo_near_full shall block only new grants. A burst already in progress continues until REQ-011 or REQ-013 applies.
- REQ-015: In IDLE, all req_ready bits and fifo_wen shall be 0.
- REQ-016: clr high shall override a same-cycle transfer:
  - fifo_wen is forced to 0 that cycle;
  - the FSM goes to IDLE;
  - last_grant is updated per REQ-012.
- REQ-017: When only one requester is valid, it shall win every arbitration with no idle bubble beyond the one IDLE cycle between bursts.

Reset
- REQ-018: With rst high at a clk edge, the next state shall be:
  - FSM = IDLE, wcnt = 0, grant_id = 0, last_grant = NREQ-1 (so requester 0 has first priority).
  - req_ready = 0, fifo_wen = 0, busy = 0.
- REQ-019: rst shall take priority over clr. rst asserted mid-burst shall drop the burst with no write that cycle.

Configuration
- REQ-020: Macro FIFO_WR_ARB_LOCK_EN controls burst locking.
  - Defined: bursts behave per REQ-011 using BURST.
  - Undefined: BURST is treated as 1, so every grant ends after one transfer and fairness is re-evaluated per word. The interface is unchanged.

Structure
- REQ-021: A shared package fifo_arb_pkg shall hold the FSM state encoding (IDLE=1'b0, BURST=1'b1) and the round-robin search function.
- REQ-022: One sub-module, rr_pick, shall implement the combinational round-robin winner search. Inputs are a request vector and last_grant; outputs are winner and any.

Verification
- REQ-023: After reset, NREQ=4, requesters 0 and 2 valid continuously, FIFO never full. Required:
  - grants alternate 0, 2, 0, 2;
  - each grant writes 4 words (LOCK_EN defined);
  - one IDLE cycle between bursts.
- REQ-024: Requester 1 in BURST; fifo_full goes high after 2 words and stays high 3 cycles. Required:
  - req_ready[1] is 0 for those 3 cycles and fifo_wen stays 0;
  - the burst resumes and completes words 3 and 4 with wdata order preserved.
- REQ-025: fifo_near_full high in IDLE with all requesters valid: busy stays 0 and fifo_wen stays 0 until near_full drops. Then requester 0 is granted one cycle later.
- REQ-026: Requester 3 drops req_valid after 1 word of a 4-word burst. Required:
  - FSM returns to IDLE the next edge with last_grant=3;
  - the next grant goes to requester 0 if requester 0 is valid.
- REQ-027: clr and rst asserted mid-burst, each in the same cycle as a valid transfer. Required:
  - fifo_wen=0 that cycle and FSM reaches IDLE next edge;
  - after rst, grant_id=0 and the first winner is the lowest-index valid requester.
- REQ-028: With FIFO_WR_ARB_LOCK_EN undefined and all 4 requesters valid, grant order shall be 0, 1, 2, 3, 0, with exactly 1 word per grant.
